// File: rtl/data_memory_access_stage.sv
// Memory-access pipeline stage: drives the data-memory bus for loads/stores,
// stalls upstream until the access completes, and registers the write-back result.
module data_memory_access_stage #(
  parameter int unsigned                COUNT_WIDTH    = 8,
  parameter logic [COUNT_WIDTH-1:0]     TIMEOUT_CYCLES = 8'd255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  RD_ADDRESS_IN,
  input  logic [31:0] ALU_OUT_IN,
  input  logic [2:0]  DATA_CACHE_LOAD_IN,
  input  logic [1:0]  DATA_CACHE_STORE_IN,
  input  logic [31:0] DATA_CACHE_STORE_DATA_IN,
  input  logic        WRITE_BACK_MUX_SELECT_IN,
  input  logic        RD_WRITE_ENABLE_IN,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        STALL_OUT,
  output logic [4:0]  RD_ADDRESS_OUT,
  output logic [31:0] RD_WRITE_DATA_OUT,
  output logic        RD_WRITE_ENABLE_OUT,
  output logic        MISALIGNED_OUT,
  output logic        BUS_ERROR_OUT
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [COUNT_WIDTH-1:0] LAST_CNT = TIMEOUT_CYCLES - COUNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   mem_we_q, mem_we_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [3:0]             mem_be_q, mem_be_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic [4:0]             rd_address_q, rd_address_d;
  logic [31:0]            rd_write_data_q, rd_write_data_d;
  logic                   rd_write_enable_q, rd_write_enable_d;
  logic                   misaligned_q, misaligned_d;
  logic                   bus_error_q, bus_error_d;

  logic        is_store, is_load, mem_op, misaligned;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic [31:0] wb_data;

  // Store takes priority when both codes are set; the load is then ignored.
  always_comb begin
    is_store   = (DATA_CACHE_STORE_IN != 2'b00);
    is_load    = !is_store && (DATA_CACHE_LOAD_IN != 3'b000);
    mem_op     = is_store || is_load;
    misaligned = 1'b0;
    if (is_store) begin
      if (DATA_CACHE_STORE_IN == 2'b10) misaligned = ALU_OUT_IN[0];
      if (DATA_CACHE_STORE_IN == 2'b11) misaligned = (ALU_OUT_IN[1:0] != 2'b00);
    end else if (is_load) begin
      if (DATA_CACHE_LOAD_IN == 3'b010 || DATA_CACHE_LOAD_IN == 3'b101)
        misaligned = ALU_OUT_IN[0];
      if (DATA_CACHE_LOAD_IN == 3'b011) misaligned = (ALU_OUT_IN[1:0] != 2'b00);
    end
  end

  always_comb begin
    store_be    = 4'b1111;
    store_wdata = '0;
    if (is_store) begin
      unique case (DATA_CACHE_STORE_IN)
        2'b01: begin
          store_be    = 4'b0001 << ALU_OUT_IN[1:0];
          store_wdata = {4{DATA_CACHE_STORE_DATA_IN[7:0]}};
        end
        2'b10: begin
          store_be    = ALU_OUT_IN[1] ? 4'b1100 : 4'b0011;
          store_wdata = {2{DATA_CACHE_STORE_DATA_IN[15:0]}};
        end
        default: store_wdata = DATA_CACHE_STORE_DATA_IN;
      endcase
    end
  end

  // Upstream is stalled during ACCESS, so the held inputs still describe the load at ACK.
  always_comb begin
    unique case (ALU_OUT_IN[1:0])
      2'b00:   lane_b = MEM_RDATA[7:0];
      2'b01:   lane_b = MEM_RDATA[15:8];
      2'b10:   lane_b = MEM_RDATA[23:16];
      default: lane_b = MEM_RDATA[31:24];
    endcase
    lane_h = ALU_OUT_IN[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    unique case (DATA_CACHE_LOAD_IN)
      3'b001:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b010:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_data = {24'd0, lane_b};
      3'b101:  load_data = {16'd0, lane_h};
      default: load_data = MEM_RDATA;
    endcase
    wb_data = WRITE_BACK_MUX_SELECT_IN ? load_data : ALU_OUT_IN;
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    mem_we_d          = mem_we_q;
    mem_addr_d        = mem_addr_q;
    mem_be_d          = mem_be_q;
    mem_wdata_d       = mem_wdata_q;
    rd_address_d      = rd_address_q;
    rd_write_data_d   = rd_write_data_q;
    rd_write_enable_d = rd_write_enable_q;
    misaligned_d      = 1'b0;
    bus_error_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!mem_op) begin
          rd_address_d      = RD_ADDRESS_IN;
          rd_write_data_d   = ALU_OUT_IN;
          rd_write_enable_d = RD_WRITE_ENABLE_IN;
        end else if (misaligned) begin
          misaligned_d      = 1'b1;
          rd_write_enable_d = 1'b0;
        end else begin
          mem_addr_d        = {ALU_OUT_IN[31:2], 2'b00};
          mem_be_d          = store_be;
          mem_we_d          = is_store;
          mem_wdata_d       = store_wdata;
          cnt_d             = '0;
          rd_write_enable_d = 1'b0;
          state_d           = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + COUNT_WIDTH'(1);
        if (MEM_ACK) begin
          rd_address_d      = RD_ADDRESS_IN;
          rd_write_data_d   = wb_data;
          rd_write_enable_d = RD_WRITE_ENABLE_IN;
          state_d           = DONE;
        end else if (cnt_q == LAST_CNT) begin
          bus_error_d       = 1'b1;
          rd_write_enable_d = 1'b0;
          state_d           = DONE;
        end
      end
      DONE: begin
        rd_write_enable_d = 1'b0;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      mem_we_q          <= 1'b0;
      mem_addr_q        <= '0;
      mem_be_q          <= '0;
      mem_wdata_q       <= '0;
      rd_address_q      <= '0;
      rd_write_data_q   <= '0;
      rd_write_enable_q <= 1'b0;
      misaligned_q      <= 1'b0;
      bus_error_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      mem_we_q          <= mem_we_d;
      mem_addr_q        <= mem_addr_d;
      mem_be_q          <= mem_be_d;
      mem_wdata_q       <= mem_wdata_d;
      rd_address_q      <= rd_address_d;
      rd_write_data_q   <= rd_write_data_d;
      rd_write_enable_q <= rd_write_enable_d;
      misaligned_q      <= misaligned_d;
      bus_error_q       <= bus_error_d;
    end
  end

  assign MEM_REQ             = (state_q == ACCESS);
  assign STALL_OUT           = (state_q == ACCESS) || ((state_q == IDLE) && mem_op && !misaligned);
  assign MEM_WE              = mem_we_q;
  assign MEM_ADDR            = mem_addr_q;
  assign MEM_BE              = mem_be_q;
  assign MEM_WDATA           = mem_wdata_q;
  assign RD_ADDRESS_OUT      = rd_address_q;
  assign RD_WRITE_DATA_OUT   = rd_write_data_q;
  assign RD_WRITE_ENABLE_OUT = rd_write_enable_q;
  assign MISALIGNED_OUT      = misaligned_q;
  assign BUS_ERROR_OUT       = bus_error_q;

endmodule
